// File: rtl/dmem_pkg.sv
// Shared widths, FSM state encoding and command record for the data-memory arbiter.
// Included by every file of the dmem_arbiter slice.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_cmd_t;

  // Word accesses only: any set byte-offset bit is an alignment error.
  function automatic logic is_misaligned(input logic [DMEM_ADDR_W-1:0] addr);
    return (addr & DMEM_ADDR_W'(3)) != '0;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between port 0 and port 1 (win = 1 means port 1).
// Round-robin on a tie when DMEM_ARB_RR_EN is defined, fixed port-0 priority otherwise.
import dmem_pkg::*;

module dmem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic win
);

`ifdef DMEM_ARB_RR_EN
  assign win = (req0 & req1) ? rr_ptr : req1;
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;
  assign win = req1 & ~req0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port 64x32 data memory: one 1-cycle access per grant,
// registered response the following cycle. Optional round-robin tie-break via DMEM_ARB_RR_EN.
import dmem_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  dmem_cmd_t         cmd_q, cmd_d;
  logic              win_q, win_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              ptr_q;
  logic              pick_win;
  logic              access, mis, rd_ok, wr_ok;

  dmem_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .rr_ptr (ptr_q),
    .win    (pick_win)
  );

`ifdef DMEM_ARB_RR_EN
  logic ptr_d;
  // Pointer only moves when both ports competed, so an uncontested stream leaves fairness intact.
  assign ptr_d = (state_q == IDLE && req0 && req1) ? ~pick_win : ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign ptr_q = 1'b0;
`endif

  assign access = (state_q == ACCESS);
  assign mis    = is_misaligned(cmd_q.addr);
  assign rd_ok  = access & ~cmd_q.we & ~mis;
  assign wr_ok  = access &  cmd_q.we & ~mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      win_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      win_q     <= win_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ACCESS;
          win_d   = pick_win;
          cmd_d   = pick_win ? '{we: we1, addr: addr1, wdata: wdata1}
                             : '{we: we0, addr: addr0, wdata: wdata0};
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response regs are zero outside the response cycle, so the idle port always reads back 0.
  always_comb begin
    rvalid0_d = access & ~win_q;
    rvalid1_d = access &  win_q;
    err0_d    = rvalid0_d & mis;
    err1_d    = rvalid1_d & mis;
    rdata0_d  = (rd_ok & ~win_q) ? mem_rdata : '0;
    rdata1_d  = (rd_ok &  win_q) ? mem_rdata : '0;
  end

  always_comb begin
    gnt0      = access & ~win_q;
    gnt1      = access &  win_q;
    mem_read  = rd_ok;
    mem_write = wr_ok;
    mem_addr  = access ? cmd_q.addr  : '0;
    mem_wdata = access ? cmd_q.wdata : '0;
    rvalid0   = rvalid0_q;
    rvalid1   = rvalid1_q;
    err0      = err0_q;
    err1      = err1_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written contention,
// withdrawn-request and reset-during-access sequences, with a response scoreboard.
import dmem_pkg::*;

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Behavioural 64x32 memory: async read, write on the clock edge.
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] = mem_wdata;

  typedef struct { int port; logic [31:0] rdata; logic err; } resp_t;
  typedef struct {
    int port; logic we; logic [7:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; logic exp_err; int exp_acc; int exp_wr;
  } vec_t;

  resp_t       sb[$];
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  int n_cmp = 0, n_mis = 0;
  int acc_cnt, wr_cnt, gnt1_cnt, gnt_port;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic rq, input logic w, input logic [7:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = rq; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = rq; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One cycle of observation: push expectations on grant, pop and compare on response.
  task automatic tick();
    resp_t r;
    @(negedge clk);
    gnt_port = -1;
    if (mem_read | mem_write) acc_cnt++;
    if (mem_write) wr_cnt++;
    if (gnt1) gnt1_cnt++;
    chk("gnt_onehot", 32'(gnt0 & gnt1), 0);
    chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 0);
    if (gnt0) begin gnt_port = 0; sb.push_back('{port: 0, rdata: exp_rdata[0], err: exp_err[0]}); end
    if (gnt1) begin gnt_port = 1; sb.push_back('{port: 1, rdata: exp_rdata[1], err: exp_err[1]}); end
    for (int p = 0; p < 2; p++) begin
      logic        rv, er;
      logic [31:0] rd;
      rv = (p == 1) ? rvalid1 : rvalid0;
      er = (p == 1) ? err1    : err0;
      rd = (p == 1) ? rdata1  : rdata0;
      if (rv) begin
        if (sb.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_rvalid: port %0d got rvalid=1, expected no response", p);
        end else begin
          r = sb.pop_front();
          chk("resp_port", p, r.port);
          chk("resp_rdata", rd, r.rdata);
          chk("resp_err", 32'(er), 32'(r.err));
        end
      end
    end
  endtask

  task automatic txn(input vec_t v);
    int cyc;
    exp_rdata[v.port] = v.exp_rdata;
    exp_err[v.port]   = v.exp_err;
    acc_cnt = 0; wr_cnt = 0;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    cyc = 0;
    do begin tick(); cyc++; end while (gnt_port != v.port && cyc < 8);
    chk("gnt_latency", cyc, 1);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    chk("rvalid_timing", 32'((v.port == 1) ? rvalid1 : rvalid0), 1);
    chk("other_port_quiet", 32'((v.port == 1) ? |{gnt0, rvalid0, err0, rdata0}
                                              : |{gnt1, rvalid1, err1, rdata1}), 0);
    chk("mem_access_count", acc_cnt, v.exp_acc);
    chk("mem_write_count", wr_cnt, v.exp_wr);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   got[4];
    int   exp_order[4];
    int   ng, cyc;

    vecs[0] = '{0, 1'b0, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0};
    vecs[1] = '{1, 1'b1, 8'h10, 32'h12345678, 32'h0,        1'b0, 1, 1};
    vecs[2] = '{1, 1'b0, 8'h10, 32'h0,        32'h12345678, 1'b0, 1, 0};
    vecs[3] = '{0, 1'b1, 8'h06, 32'hFFFFFFFF, 32'h0,        1'b1, 0, 0};
    vecs[4] = '{0, 1'b0, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0};
    vecs[5] = '{1, 1'b0, 8'h03, 32'h0,        32'h0,        1'b1, 0, 0};
    vecs[6] = '{0, 1'b1, 8'hFC, 32'hCAFEF00D, 32'h0,        1'b0, 1, 1};
    vecs[7] = '{1, 1'b0, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0, 1, 0};
    vecs[8] = '{0, 1'b0, 8'h08, 32'h0,        32'h0,        1'b0, 1, 0};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'hDEADBEEF;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b1;

    tick(); tick();
    chk("rst_gnt0", 32'(gnt0), 0);       chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0); chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_err0", 32'(err0), 0);       chk("rst_err1", 32'(err1), 0);
    chk("rst_rdata0", rdata0, 0);        chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    tick();
    chk("idle_no_access", 32'(mem_read | mem_write), 0);

    for (int i = 0; i < 9; i++) txn(vecs[i]);

    // Withdrawn request: req1 pulses inside port 0's access cycle and is never sampled.
    exp_rdata[0] = 32'hDEADBEEF; exp_err[0] = 1'b0;
    acc_cnt = 0; gnt1_cnt = 0;
    drive(0, 1'b1, 1'b0, 8'h04, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 8'h20, 32'h55AA55AA);
    tick();
    chk("wd_gnt0", 32'(gnt0), 1);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    chk("wd_rvalid0", 32'(rvalid0), 1);
    tick(); tick();
    chk("wd_no_gnt1", gnt1_cnt, 0);
    chk("wd_single_access", acc_cnt, 1);
    chk("wd_sb_drained", sb.size(), 0);

    // Contention: both ports stream reads.
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    got = '{-1, -1, -1, -1};
    exp_rdata[0] = 32'hDEADBEEF; exp_rdata[1] = 32'h12345678;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    gnt1_cnt = 0; ng = 0; cyc = 0;
    drive(0, 1'b1, 1'b0, 8'h04, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h10, 32'h0);
    while (ng < 4 && cyc < 40) begin
      tick(); cyc++;
      if (gnt_port >= 0) begin got[ng] = gnt_port; ng++; end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(); tick();
    for (int i = 0; i < 4; i++) chk("contention_grant_order", got[i], exp_order[i]);
`ifndef DMEM_ARB_RR_EN
    chk("fixed_prio_no_gnt1", gnt1_cnt, 0);
`endif
    chk("cont_sb_drained", sb.size(), 0);

    // Reset asserted in the middle of a port-1 write.
    gnt1_cnt = 0;
    drive(1, 1'b1, 1'b1, 8'h20, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("ra_write_active", 32'(mem_write), 1);
    chk("ra_gnt1_active", 32'(gnt1), 1);
    reset = 1'b1;
    #1;
    chk("ra_write_dropped", 32'(mem_write), 0);
    chk("ra_gnt1_dropped", 32'(gnt1), 0);
    chk("ra_mem_addr", 32'(mem_addr), 0);
    chk("ra_state_idle", 32'(dut.state_q), 32'(IDLE));
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("ra_no_regrant", gnt1_cnt, 0);
    chk("ra_sb_empty", sb.size(), 0);
    txn('{1, 1'b0, 8'h20, 32'h0, 32'h0, 1'b0, 1, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port 64×32 data memory. It shares the memory between the core load/store port (port 0) and the debug/DMA loader port (port 1). Each transaction is latched and driven onto the memory's sync-write/async-read interface for exactly one cycle. Read data and status come back through a registered response.

## Interface
Parameters:
- ADDR_W, 8, byte address width (64 words, word index = addr[7:2])
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  request; held high with stable command until gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse; requester may drop or change req after this edge
- rvalid0 / rvalid1  out  1  one-cycle response pulse
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid; 0 for writes and errors
- err0 / err1  out  1  misaligned-access flag, valid with rvalid
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory write_data
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_rdata  in  DATA_W  from memory read_data

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - If any req is high, pick a winner per the arbitration policy.
  - Latch its we, addr and wdata, plus the winner id, into command registers. Go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - Assert gnt of the winner.
  - Drive mem_addr and mem_wdata from the command registers. Drive mem_read = ~we and mem_write = we.
  - On the closing edge, a write commits in memory, or mem_rdata is captured into the winner's rdata register.
  - Always return to IDLE.
- Response: the winner's rvalid is high for the cycle after ACCESS; err is set in the same cycle.
- Misaligned request (addr[1:0] ≠ 0):
  - Granted normally, but mem_read and mem_write stay 0 during ACCESS.
  - Response has err = 1 and rdata = 0. Memory is untouched.
- Arbitration with both requests high in IDLE is set by the policy in Configuration. With only one request high, that port always wins.
- Memory-side outputs outside ACCESS: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
- A requester whose req drops before gnt has withdrawn; no transaction occurs.

## Timing
- Reset values:
  - State IDLE.
  - gnt0/1, rvalid0/1, err0/1, mem_read and mem_write all 0.
  - rdata0/1 = 0, mem_addr = 0, mem_wdata = 0.
  - Round-robin pointer (when compiled in) points to port 0 as next priority.
- Latency: req sampled at edge N (IDLE), ACCESS and gnt in cycle N+1, rvalid in cycle N+2.
- Throughput: one transaction per 2 cycles. A new request can be accepted in the same cycle as the previous response's rvalid.
- Asserting reset during ACCESS:
  - All outputs clear asynchronously and mem_write drops immediately, so no write commits.
  - No response is issued. The requester must reissue after reset.
- gnt, rvalid and err are registered or state-decoded; they have no combinational path from req.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Round-robin when both ports request in IDLE.
  - A 1-bit pointer flips to the other port after each granted transaction on the contested path.
  - Port 1 is therefore never starved longer than one port-0 transaction.
- Not defined:
  - Fixed priority; port 0 always wins a tie.
  - The pointer register is not present.

## Structure
- Package dmem_pkg holds:
  - DMEM_ADDR_W = 8, DMEM_DATA_W = 32, DMEM_DEPTH = 64.
  - Enum arb_state_t {IDLE, ACCESS}.
  - Struct dmem_cmd_t {we, addr, wdata}.
  - Function is_misaligned(addr).
- Sub-module dmem_arb_pick: pure combinational winner selection from req0, req1 and the rr pointer. It contains the DMEM_ARB_RR_EN conditional.

## Test plan
- Single read: port 0 reads addr 0x04 holding 0xDEADBEEF → gnt0 in cycle 1, rvalid0 in cycle 2, rdata0 = 0xDEADBEEF, err0 = 0.
- Write then read: port 1 writes 0x12345678 to 0x10, then reads 0x10 → second response has rdata1 = 0x12345678; port 0 outputs stay 0.
- Contention:
  - Both ports continuously request reads.
  - With DMEM_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without it: port 1 gets no grant while req0 stays high.
- Misaligned: port 0 writes 0xFFFFFFFF to 0x06 → mem_write never asserted, err0 = 1 with rvalid0; a read of 0x04 returns its old value.
- Reset in ACCESS: assert reset during a port-1 write of 0xA5A5A5A5 to 0x20 → mem_write falls immediately, no rvalid1, FSM in IDLE; after release, 0x20 reads 0.
- Withdrawn request: pulse req1 for zero cycles while port 0 holds the bus → no gnt1, no memory access for port 1.
